aes_key_sched_seq: RTL and testbench
====================================

// Module: aes_key_sched_seq
// PURPOSE
//  Sequential AES key schedule supporting AES-128/192/256, selected per request.
//  - Generates one 32-bit schedule word per cycle and shares one SubWord unit.
//  - Delivers the 128-bit round keys rk0..rkNr in order on a valid/ready stream.
//  - Sits between key load and the round datapath, replacing a fully unrolled expander.
// PARAMETERS
//  SUPPORT_192  1  Enables the 192-bit mode. When 0, key_len=01 is illegal.
//  SUPPORT_256  1  Enables the 256-bit mode. When 0, key_len=10 is illegal.
// PORTS
//  clk         in   1    Clock. Single clock domain.
//  rst_n       in   1    Reset. Asynchronous assert, active-low.
//  start       in   1    Request a schedule. Accepted when start && start_ready.
//  start_ready out  1    High in IDLE only.
//  key_len     in   2    00=128, 01=192, 10=256, 11=illegal. Sampled at acceptance.
//  key         in   256  Key, MSB-aligned: w0=key[255:224]. Unused LSBs are ignored.
//  cfg_err     out  1    One-cycle pulse when start targets an illegal or disabled key_len.
//  busy        out  1    High from acceptance until the final rk handshake.
//  rk_valid    out  1    Round key available.
//  rk_ready    in   1    Consumer accepts the round key.
//  rk_data     out  128  Round key, {w4r, w4r+1, w4r+2, w4r+3}.
//  rk_index    out  4    Round number r, 0..Nr.
//  rk_last     out  1    High with rk_valid when r==Nr.
// BEHAVIOUR
//  Reset: all outputs 0 except start_ready=1. FSM=IDLE, window and counters cleared.
//  Mode constants: Nk=4/6/8 and Nr=10/12/14. Total words T=4(Nr+1)=44/52/60.
//  FSM states IDLE -> RUN -> IDLE. There is no separate done state.
//  IDLE:
//   - On start with a legal key_len: latch key and Nk, set word count w=0, j=0 (w mod Nk), rcon=01, then go to RUN.
//   - On start with an illegal key_len: pulse cfg_err and stay in IDLE. No state changes.
//  RUN: the advance condition is adv = (w<T) && !(rk_valid && !rk_ready). On each adv cycle, produce word W[w]:
//   - w<Nk: W = latched key word w.
//   - j==0: W = win[Nk-1] ^ SubWord(RotWord(win[0])) ^ {rcon,24'h0}; then rcon <= xtime(rcon) (80->1B->36).
//   - Nk==8 && j==4: W = win[Nk-1] ^ SubWord(win[0]).
//   - Otherwise: W = win[Nk-1] ^ win[0].
//   - win is an 8x32 shift register, newest at [0]. Shift W in; w++, j wraps at Nk-1.
//  Assembly:
//   - Words 0..2 of each round key go to a 3-word buffer.
//   - On the 4th word, rk_data/rk_index load, rk_valid is set, and rk_last = (r==Nr).
//  Handshake:
//   - rk_valid && rk_ready clears rk_valid unless a new key loads in the same cycle. Load wins.
//   - rk_data is stable while rk_valid && !rk_ready. Generation stalls and win/w/j/rcon hold.
//  Latency:
//   - Acceptance is at edge E0. Words are produced at E1..; rk0 is valid after E4.
//   - With rk_ready tied high, one rk every 4 cycles. rkNr is valid after E44/E52/E60.
//  Completion:
//   - The rk_last handshake returns the FSM to IDLE; busy drops and start_ready rises next cycle.
//   - The next start may be accepted on the following edge.
//  Boundaries:
//   - start while busy is ignored.
//   - key/key_len changes during RUN have no effect.
//   - rk_ready may be high with rk_valid low; this has no effect.
//  Reset mid-operation: immediate return to reset state. A partial schedule is discarded and rk_valid drops asynchronously.
//  Width rules: all XORs are 32-bit. rcon is 8-bit with GF(2^8) doubling mod 11B.
// STRUCTURE
//  aes_pkg:
//   - sbox function (256-entry) and xtime function.
//   - KEY_LEN_128/192/256 localparams.
//   - NK/NR lookup functions.
//  aes_sub_word: sub-module of 4 combinational S-box lanes, 32-bit in -> 32-bit out. One instance.
//  Top: FSM, counters w/j/r, rcon register, window, assembly buffer, output registers.
// TESTING
//  1. AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
//     rk0=key, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_last at rk_index 10, 44 cycles.
//  2. AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//     rk12=e98ba06f448c773c8ecc720401002202, 13 keys.
//  3. AES-256, key 603deb10...0914dff4 (FIPS-197 A.3):
//     rk14=fe4890d1e6188d0b046df344706c631e, 15 keys.
//  4. Random rk_ready backpressure, all modes:
//     keys identical to tests 1-3, rk_data stable while stalled, no drops or duplicates.
//  5. start with key_len=11, and with key_len=01 when SUPPORT_192=0:
//     cfg_err pulses for 1 cycle, busy stays 0, no rk_valid.
//  6. rst_n low at rk_index 5, then a new AES-128 start:
//     rk_valid=0 at once, start_ready=1, new schedule correct from rk0.
//     Also: start during RUN is ignored.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KEY_LEN_192: return 4'd12;
            KEY_LEN_256: return 4'd14;
            default:     return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel combinational S-box lanes.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128/192/256 key schedule: one word per cycle,
// round keys streamed out on a valid/ready interface.
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter bit SUPPORT_192 = 1'b1,
    parameter bit SUPPORT_256 = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         start_ready,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         cfg_err,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last
);

    state_t         r_state;
    logic [255:0]   r_key;
    logic [2:0]     r_nkm1;
    logic [3:0]     r_nr;
    logic [5:0]     r_w;
    logic [2:0]     r_j;
    logic [7:0]     r_rcon;
    logic [31:0]    r_win [8];
    logic [31:0]    r_buf [3];
    logic           r_start_ready;
    logic           r_busy;
    logic           r_cfg_err;
    logic           r_rk_valid;
    logic [127:0]   r_rk_data;
    logic [3:0]     r_rk_index;
    logic           r_rk_last;

    logic           w_illegal;
    logic           w_accept;
    logic           w_adv;
    logic           w_key_phase;
    logic           w_hs;
    logic           w_load;
    logic [5:0]     w_total;
    logic [31:0]    w_prev_nk;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_word;

    always_comb begin
        w_illegal   = (key_len == 2'b11)
                    || (key_len == KEY_LEN_192 && !SUPPORT_192)
                    || (key_len == KEY_LEN_256 && !SUPPORT_256);
        w_accept    = (r_state == ST_IDLE) && start && !w_illegal;
        w_total     = {r_nr + 4'd1, 2'b00};
        w_adv       = (r_state == ST_RUN) && (r_w < w_total)
                    && !(r_rk_valid && !rk_ready);
        w_key_phase = (r_w <= {3'b000, r_nkm1});
        w_hs        = r_rk_valid && rk_ready;
        w_load      = w_adv && (r_w[1:0] == 2'd3);
        w_prev_nk   = r_win[r_nkm1];
        w_sub_in    = (r_j == 3'd0) ? {r_win[0][23:0], r_win[0][31:24]}
                                    : r_win[0];
    end

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Key words come from the top of the shifting key register.
    always_comb begin
        w_word = w_prev_nk ^ r_win[0];
        if (w_key_phase)
            w_word = r_key[255:224];
        else if (r_j == 3'd0)
            w_word = w_prev_nk ^ w_sub_out ^ {r_rcon, 24'h0};
        else if (r_nkm1 == 3'd7 && r_j == 3'd4)
            w_word = w_prev_nk ^ w_sub_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_key         <= '0;
            r_nkm1        <= '0;
            r_nr          <= '0;
            r_w           <= '0;
            r_j           <= '0;
            r_rcon        <= '0;
            for (int i = 0; i < 8; i++) r_win[i] <= '0;
            for (int i = 0; i < 3; i++) r_buf[i] <= '0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_rk_valid    <= 1'b0;
            r_rk_data     <= '0;
            r_rk_index    <= '0;
            r_rk_last     <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == ST_IDLE) && start && w_illegal;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state       <= ST_RUN;
                        r_busy        <= 1'b1;
                        r_start_ready <= 1'b0;
                        r_key         <= key;
                        r_nkm1        <= 3'(nk_of(key_len) - 4'd1);
                        r_nr          <= nr_of(key_len);
                        r_w           <= '0;
                        r_j           <= '0;
                        r_rcon        <= 8'h01;
                    end
                end
                default: begin
                    if (w_hs && r_rk_last) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                    end
                end
            endcase

            if (w_adv) begin
                for (int i = 7; i > 0; i--) r_win[i] <= r_win[i-1];
                r_win[0] <= w_word;
                r_key    <= {r_key[223:0], 32'h0};
                r_w      <= r_w + 6'd1;
                r_j      <= (r_j == r_nkm1) ? 3'd0 : r_j + 3'd1;
                if (!w_key_phase && r_j == 3'd0)
                    r_rcon <= xtime(r_rcon);
                case (r_w[1:0])
                    2'd0:    r_buf[0] <= w_word;
                    2'd1:    r_buf[1] <= w_word;
                    2'd2:    r_buf[2] <= w_word;
                    default: ;
                endcase
            end

            // A fresh round key overrides the clear from a handshake.
            if (w_load) begin
                r_rk_valid <= 1'b1;
                r_rk_data  <= {r_buf[0], r_buf[1], r_buf[2], w_word};
                r_rk_index <= r_w[5:2];
                r_rk_last  <= (r_w[5:2] == r_nr);
            end else if (w_hs) begin
                r_rk_valid <= 1'b0;
                r_rk_last  <= 1'b0;
            end
        end
    end

    assign start_ready = r_start_ready;
    assign busy        = r_busy;
    assign cfg_err     = r_cfg_err;
    assign rk_valid    = r_rk_valid;
    assign rk_data     = r_rk_data;
    assign rk_index    = r_rk_index;
    assign rk_last     = r_rk_last;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed + randomized bench for aes_key_sched_seq against a
// FIPS-197 style key expansion model with a computed S-box.
module tb_aes_key_sched_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         start_ready;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         cfg_err;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;

    logic         b_start;
    logic         b_start_ready;
    logic [1:0]   b_key_len;
    logic         b_cfg_err;
    logic         b_busy;
    logic         b_rk_valid;
    logic [127:0] b_rk_data;
    logic [3:0]   b_rk_index;
    logic         b_rk_last;

    int checks = 0;
    int errors = 0;

    logic [7:0]   ref_sbox [0:255];
    logic [127:0] exp_rk   [0:14];
    logic [127:0] got_rk   [0:14];
    int           exp_nr;

    aes_key_sched_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .key_len(key_len), .key(key), .cfg_err(cfg_err), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_index(rk_index), .rk_last(rk_last)
    );

    aes_key_sched_seq #(.SUPPORT_192(1'b0), .SUPPORT_256(1'b1)) dut_no192 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .start_ready(b_start_ready),
        .key_len(b_key_len), .key(key), .cfg_err(b_cfg_err), .busy(b_busy),
        .rk_valid(b_rk_valid), .rk_ready(1'b1), .rk_data(b_rk_data),
        .rk_index(b_rk_index), .rk_last(b_rk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            end
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                        ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {ref_sbox[v[31:24]], ref_sbox[v[23:16]],
                ref_sbox[v[15:8]],  ref_sbox[v[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k, input logic [1:0] kl);
        logic [31:0] wv [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        nk = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
        exp_nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (exp_nr + 1); i++) begin
            if (i < nk) begin
                wv[i] = k[255 - 32*i -: 32];
            end else begin
                t = wv[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                wv[i] = wv[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= exp_nr; r++)
            exp_rk[r] = {wv[4*r], wv[4*r+1], wv[4*r+2], wv[4*r+3]};
    endtask

    task automatic run_sched(input logic [255:0] k, input logic [1:0] kl,
                             input bit bp);
        int  n = 0;
        int  cyc = 0;
        int  first = -1;
        int  last_cyc = -1;
        bit  done = 0;
        bit  prev_stall = 0;
        logic [127:0] prev_data = '0;
        logic [3:0]   prev_idx = '0;
        model_expand(k, kl);
        @(negedge clk);
        start = 1'b1; key = k; key_len = kl;
        rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
        key_len = 2'($urandom_range(0, 3));
        chk1("busy_after_accept", busy, 1'b1);
        chk1("start_ready_in_run", start_ready, 1'b0);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bp) begin
                start = 1'($urandom_range(0, 1));
                key = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
                key_len = 2'($urandom_range(0, 3));
            end
            if (prev_stall) begin
                chk1("held_valid", rk_valid, 1'b1);
                chk("held_data", rk_data, prev_data);
                chk("held_index", 128'(rk_index), 128'(prev_idx));
            end
            if (rk_valid) begin
                if (first < 0) first = cyc;
                rk_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (rk_ready) begin
                    chk("rk_index", 128'(rk_index), 128'(n));
                    chk("rk_data", rk_data, exp_rk[n]);
                    chk1("rk_last", rk_last, 1'(n == exp_nr));
                    got_rk[n] = rk_data;
                    if (rk_last) last_cyc = cyc;
                    n++;
                    if (n == exp_nr + 1) begin
                        done = 1;
                        start = 1'b0;
                    end
                end
                prev_stall = !rk_ready;
                prev_data = rk_data;
                prev_idx = rk_index;
            end else begin
                rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                prev_stall = 0;
            end
        end
        chk1("sched_complete", done, 1'b1);
        if (!bp) begin
            chk("first_rk_latency", 128'(first), 128'(4));
            chk("last_rk_latency", 128'(last_cyc), 128'(4 * (exp_nr + 1)));
        end
        start = 1'b0;
        @(negedge clk);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_start_ready", start_ready, 1'b1);
        chk1("idle_no_extra_rk", rk_valid, 1'b0);
    endtask

    initial begin
        logic [255:0] k128;
        logic [255:0] k192;
        logic [255:0] k256;
        logic [255:0] krnd;
        logic [1:0]   klrnd;
        bit           found;

        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        rst_n = 1'b0; start = 1'b0; key_len = 2'b00; key = '0; rk_ready = 1'b0;
        b_start = 1'b0; b_key_len = 2'b00;
        build_sbox();
        #12;
        chk1("rst_start_ready", start_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rk_valid", rk_valid, 1'b0);
        chk1("rst_cfg_err", cfg_err, 1'b0);
        chk1("rst_rk_last", rk_last, 1'b0);
        chk("rst_rk_data", rk_data, 128'h0);
        chk("rst_rk_index", 128'(rk_index), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_sched(k128, 2'b00, 1'b0);
        chk("kat128_rk0", got_rk[0], k128[255:128]);
        chk("kat128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_sched(k192, 2'b01, 1'b0);
        chk("kat192_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        run_sched(k256, 2'b10, 1'b0);
        chk("kat256_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_sched(k128, 2'b00, 1'b1);
        chk("bp128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_sched(k192, 2'b01, 1'b1);
        chk("bp192_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        run_sched(k256, 2'b10, 1'b1);
        chk("bp256_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        for (int t = 0; t < 3; t++) begin
            krnd = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            klrnd = 2'($urandom_range(0, 2));
            run_sched(krnd, klrnd, 1'b1);
        end

        @(negedge clk);
        start = 1'b1; key_len = 2'b11; rk_ready = 1'b1;
        b_start = 1'b1; b_key_len = 2'b01;
        @(negedge clk);
        start = 1'b0; b_start = 1'b0;
        chk1("ill11_cfg_err", cfg_err, 1'b1);
        chk1("ill11_busy", busy, 1'b0);
        chk1("ill11_start_ready", start_ready, 1'b1);
        chk1("no192_cfg_err", b_cfg_err, 1'b1);
        chk1("no192_busy", b_busy, 1'b0);
        @(negedge clk);
        chk1("ill11_pulse_end", cfg_err, 1'b0);
        chk1("no192_pulse_end", b_cfg_err, 1'b0);
        @(negedge clk);
        chk1("ill11_no_rk", rk_valid, 1'b0);
        chk1("no192_no_rk", b_rk_valid, 1'b0);
        chk1("no192_idle", b_start_ready, 1'b1);

        @(negedge clk);
        start = 1'b1; key = k256; key_len = 2'b00;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (rk_valid && rk_index == 4'd5) found = 1;
        end
        chk1("reach_rk5", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst_rk_valid", rk_valid, 1'b0);
        chk1("async_rst_start_ready", start_ready, 1'b1);
        chk1("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sched(k128, 2'b00, 1'b0);
        chk("post_rst_rk0", got_rk[0], k128[255:128]);
        chk("post_rst_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
